modport_fifo: RTL and testbench
===============================

Name: modport_fifo

Overview:
- Single-clock synchronous FIFO. Default entries are 128 bits wide.
- Buffers write-channel data between a producer (wr_en/wr_data) and a consumer (rd_en/rd_data).
- Reports full/empty status; sits in the write-data path of the AXI-side logic.
- Pointer-based circular buffer with registered read data.

Parameters:
- DATA_W, 128, width of each entry and of wr_data/rd_data.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data, sampled on a rising clk edge when the write is accepted.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  registered read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.

Behaviour:
- Reset (rst low, asynchronous assert, released synchronously to clk):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, rd_data=0.
  - Storage contents are not reset.
- Write acceptance: write accepted iff wr_en && !full.
  - Stores wr_data at wr_ptr; wr_ptr increments modulo DEPTH.
  - wr_en while full is ignored: no state change, data dropped.
- Read acceptance: read accepted iff rd_en && !empty.
  - rd_data loads mem[rd_ptr] at that rising edge, so the data is valid from the next cycle (1-cycle latency).
  - rd_ptr increments modulo DEPTH.
  - rd_en while empty is ignored and rd_data holds its last value.
- rd_data changes only on an accepted read or on reset.
- Simultaneous accepted read and write: both proceed and count is unchanged.
- Full while rd_en and wr_en are both high: only the read is accepted, because full is evaluated before the edge. Count becomes DEPTH-1.
- Empty while rd_en and wr_en are both high: only the write is accepted. No write-to-read bypass; the entry is readable in a later cycle.
- Flags:
  - full = (count == DEPTH); empty = (count == 0).
  - Both are registered or derived from the registered count, so they are glitch-free and valid in the same cycle as the count update.
- Counter: count has width ADDR_W+1 and ranges 0..DEPTH. Pointers wrap naturally at DEPTH.
- Reset mid-operation: all pointers and flags return immediately to their reset values. In-flight data is discarded.
- Ordering: strict FIFO. Data read out equals data written, in order, with no duplication or loss of accepted entries.

Optional Feature:
- Macro: MODPORT_FIFO_LEVEL_EN.
- When defined: adds output port data_count, width ADDR_W+1, equal to the current count.
  - Resets to 0.
  - Updates on the same edge as full/empty.
- When undefined: port absent; count is kept internally only. Functional behaviour is otherwise identical.

Decomposition:
- Package modport_fifo_pkg holds:
  - localparam FIFO_DATA_W=128 and FIFO_DEPTH=16.
  - typedef logic [FIFO_DATA_W-1:0] fifo_data_t.
- One sub-module, modport_fifo_mem: a simple dual-port array.
  - Synchronous write port: we, waddr, wdata.
  - Synchronous registered read port: re, raddr, rdata.
  - No reset on the array.
- Pointer, count and flag logic lives in the top module.

Test Plan:
- Reset: assert rst=0 mid-simulation after 5 writes -> empty=1, full=0, rd_data=0 immediately. A subsequent read is ignored.
- Fill/drain: write 0x1..0x10 (16 writes) -> full=1 after the 16th edge. Then 16 reads -> rd_data sequence 0x1..0x10, each one cycle after its rd_en, and empty=1 after the last.
- Overflow: when full, drive wr_en with 0xDEAD -> ignored. Draining yields 0x1..0x10 with no 0xDEAD.
- Underflow: when empty, pulse rd_en -> rd_data unchanged, empty stays 1, pointers unchanged.
- Simultaneous read/write at half level (8 entries): 10 cycles with wr_en=rd_en=1 -> count stays 8 and data stays in order. Pointer wrap past index 15 is exercised.
- Corner: full with wr_en=rd_en=1 -> only the read accepted, full=0 next cycle. Empty with both high -> only the write accepted, empty=0 next cycle, rd_data unchanged.

Source files
------------

// File: rtl/modport_fifo_pkg.sv
// Shared constants and types for the modport_fifo write-data buffer.
package modport_fifo_pkg;

  localparam int FIFO_DATA_W = 128;
  localparam int FIFO_DEPTH  = 16;

  typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

endpackage

// File: rtl/modport_fifo_mem.sv
// Simple dual-port storage array for modport_fifo.
// It has one synchronous write port and one registered read port.
// The array and the read register are never reset.
module modport_fifo_mem
  import modport_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming entry at the write address
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Register the addressed entry; hold it when no read is requested
  always_ff @(posedge clk) begin
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/modport_fifo.sv
// Single-clock circular-buffer FIFO with registered read data.
// Pointer, count and flag logic lives here; storage is in modport_fifo_mem.
// Optional macro MODPORT_FIFO_LEVEL_EN adds a data_count output carrying the fill level.
// DEPTH must be a power of two and at least 2, so the pointers wrap naturally.
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty
`ifdef MODPORT_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] data_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  // Set by the first accepted read after reset. Until then rd_data is
  // forced to zero, because the unreset array read register is stale.
  logic              rd_vld_q, rd_vld_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // The flags come from the registered count, so they are glitch-free.
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign rd_data = rd_vld_q ? mem_rdata : '0;

`ifdef MODPORT_FIFO_LEVEL_EN
  assign data_count = count_q;
`endif

  // Next-state for the pointers, the occupancy count and the read-valid flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_vld_d = rd_vld_q | rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; asynchronous reset discards all queued entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  modport_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_modport_fifo.sv
// Scoreboard bench for modport_fifo: the driver pushes expected read data,
// and a negedge monitor pops the data and compares it against the DUT outputs.
module tb_modport_fifo;
  import modport_fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  fifo_data_t wr_data;
  fifo_data_t rd_data;
  logic       full;
  logic       empty;
`ifdef MODPORT_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] data_count;
`endif

  always #5 clk = ~clk;

  modport_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
`ifdef MODPORT_FIFO_LEVEL_EN
    ,
    .data_count (data_count)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  fifo_data_t model_q[$];
  fifo_data_t exp_q[$];
  fifo_data_t last_rd = '0;
  bit         rd_fired = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: on the falling edge, compare the read data and the flags
  always @(negedge clk) begin
    if (rd_fired) begin
      rd_fired = 1'b0;
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        last_rd = exp_q.pop_front();
        check("rd_data", rd_data, last_rd);
      end
    end else begin
      check("rd_hold", rd_data, last_rd);
    end
    check("full", full, 128'(model_q.size() == DEPTH));
    check("empty", empty, 128'(model_q.size() == 0));
`ifdef MODPORT_FIFO_LEVEL_EN
    check("data_count", data_count, 128'(model_q.size()));
`endif
  end

  // One clock of stimulus. Acceptance is decided from the model's pre-edge level.
  task automatic cycle(input bit we, input fifo_data_t wd, input bit re);
    bit wacc, racc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wacc = we && (model_q.size() < DEPTH);
    racc = re && (model_q.size() > 0);
    @(posedge clk);
    if (racc) begin
      exp_q.push_back(model_q.pop_front());
      rd_fired = 1'b1;
    end
    if (wacc) model_q.push_back(wd);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 0);
    model_q.delete();
    exp_q.delete();
    last_rd  = '0;
    rd_fired = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("init_empty", empty, 1);
    check("init_full", full, 0);
    check("init_rd_data", rd_data, 0);
    rst = 1'b1;

    // Reset in the middle of operation, then a read that must be ignored
    for (int i = 1; i <= 5; i++) cycle(1'b1, fifo_data_t'(128'hA0 + i), 1'b0);
    check("pre_rst_empty", empty, 0);
    do_reset();
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("post_rst_read_ignored", rd_data, 0);
    check("post_rst_empty", empty, 1);

    // Fill with 0x1..0x10, then try an overflow write
    for (int i = 1; i <= 16; i++) cycle(1'b1, fifo_data_t'(i), 1'b0);
    check("fill_full", full, 1);
    cycle(1'b1, fifo_data_t'(128'hDEAD), 1'b0);
    check("ovf_full", full, 1);

    // Drain: the reads return 0x1..0x10, and 0xDEAD never appears
    for (int i = 1; i <= 16; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("drain_last", rd_data, 128'h10);
    check("drain_empty", empty, 1);

    // Underflow: the reads are ignored and rd_data holds its value
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("uflow_rd_data", rd_data, 128'h10);
    check("uflow_empty", empty, 1);

    // Half level plus simultaneous read/write; the pointers wrap past 15
    for (int i = 0; i < 8; i++) cycle(1'b1, fifo_data_t'(128'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, fifo_data_t'(128'h28 + i), 1'b1);
    check("rw_not_full", full, 0);
    check("rw_not_empty", empty, 0);
    cycle(1'b0, '0, 1'b0);
    check("rw_last_out", rd_data, 128'h29);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("rw_drain_last", rd_data, 128'h31);
    check("rw_drain_empty", empty, 1);

    // Full with both requests high: only the read is accepted
    for (int i = 0; i < 16; i++) cycle(1'b1, fifo_data_t'(128'h40 + i), 1'b0);
    check("corner_full", full, 1);
    cycle(1'b1, fifo_data_t'(128'hBEEF), 1'b1);
    check("corner_full_drops", full, 0);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("corner_drain_last", rd_data, 128'h4F);
    check("corner_drain_empty", empty, 1);

    // Empty with both requests high: only the write is accepted, with no bypass
    cycle(1'b1, fifo_data_t'(128'h77), 1'b1);
    check("corner_empty_fills", empty, 0);
    check("corner_empty_no_bypass", rd_data, 128'h4F);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("corner_bypass_later", rd_data, 128'h77);
    check("final_empty", empty, 1);

    check("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
